// File: rtl/rx_bit_sequencer_pkg.sv
// Shared definitions for the UART receive engine blocks.
//   - ST_IDLE / ST_RUN : bit sequencer state encodings
//   - DEF_DIV_W / DEF_CNT_W : default divisor and frame-count widths
package rx_bit_sequencer_pkg;

    localparam int unsigned DEF_DIV_W = 19;
    localparam int unsigned DEF_CNT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/rx_bit_sequencer_if.sv
// Control/status bundle between the receive control FSM and the bit sequencer.
//   master (control FSM) : drives start, abort, divisor, bit_count, half_first
//                          and observes busy, btu, done, count
//   slave  (sequencer)   : the reverse
interface rx_bit_sequencer_if
    import rx_bit_sequencer_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) ();

    logic             start;
    logic             abort;
    logic [DIV_W-1:0] divisor;
    logic [CNT_W-1:0] bit_count;
    logic             half_first;
    logic             busy;
    logic             btu;
    logic             done;
    logic [CNT_W-1:0] count;

    modport master (
        output start, abort, divisor, bit_count, half_first,
        input  busy, btu, done, count
    );

    modport slave (
        input  start, abort, divisor, bit_count, half_first,
        output busy, btu, done, count
    );

endinterface

// File: rtl/rx_bit_sequencer_bit_timer.sv
// Bit-time down-counter with load/reload and terminal-count decode.
//   Clk, Rst  : clock, synchronous active-high reset
//   clr       : force timer to 0 (frame cancelled)
//   en        : allow decrement
//   load      : load load_val at the start of a frame (first interval)
//   reload    : load load_val at each bit-time-up
//   load_val  : value for load/reload
//   tc        : timer == 1, the last cycle of the current interval
module rx_bit_sequencer_bit_timer
    import rx_bit_sequencer_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic             reload,
    input  logic [DIV_W-1:0] load_val,
    output logic             tc
);

    logic [DIV_W-1:0] timer;

    // Down-counter that parks at 1 until reloaded.
    always_ff @(posedge Clk) begin
        if (Rst || clr) begin
            timer <= '0;
        end else if (load || reload) begin
            timer <= load_val;
        end else if (en && (timer > DIV_W'(1))) begin
            timer <= timer - DIV_W'(1);
        end
    end

    assign tc = (timer == DIV_W'(1));

endmodule

// File: rtl/rx_bit_sequencer.sv
// Bit-time generator and bit counter for the UART receive engine.
// On an accepted start it emits one btu strobe per bit time (optionally with a
// half-length first interval) and pulses done together with the final btu.
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : slave side of rx_bit_sequencer_if
//              (start/abort/divisor/bit_count/half_first in,
//               busy/btu/done/count out)
module rx_bit_sequencer
    import rx_bit_sequencer_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                Clk,
    input  logic                Rst,
    rx_bit_sequencer_if.slave   bus
);

    rx_state_t        state;
    logic [DIV_W-1:0] div_l;
    logic [CNT_W-1:0] bc_l;
    logic [CNT_W-1:0] count;

    logic             accept;
    logic [DIV_W-1:0] div_in;
    logic [DIV_W-1:0] div_half;
    logic [DIV_W-1:0] first_val;
    logic             tc;
    logic             btu_c;
    logic             done_c;

    // A start with a zero-length frame is ignored in every state.
    assign accept    = bus.start && (bus.bit_count != '0);
    assign div_in    = (bus.divisor == '0) ? DIV_W'(1) : bus.divisor;
    assign div_half  = div_in >> 1;
    assign first_val = bus.half_first ? ((div_half == '0) ? DIV_W'(1) : div_half)
                                      : div_in;

    // Strobe is a decode of registered state; a restart or abort on the same
    // edge swallows it so the cancelled frame never reports a bit or done.
    assign btu_c  = (state == ST_RUN) && tc && !bus.abort && !accept;
    assign done_c = btu_c && (count == (bc_l - CNT_W'(1)));

    // State, latched frame parameters and completed-bit count.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_IDLE;
            count <= '0;
            div_l <= DIV_W'(1);
            bc_l  <= '0;
        end else if (bus.abort) begin
            state <= ST_IDLE;
            count <= '0;
        end else if (accept) begin
            state <= ST_RUN;
            div_l <= div_in;
            bc_l  <= bus.bit_count;
            count <= '0;
        end else if (btu_c) begin
            count <= count + CNT_W'(1);
            if (done_c) begin
                state <= ST_IDLE;
            end
        end
    end

    rx_bit_sequencer_bit_timer #(
        .DIV_W (DIV_W)
    ) u_bit_timer (
        .Clk      (Clk),
        .Rst      (Rst),
        .clr      (bus.abort),
        .en       (state == ST_RUN),
        .load     (accept && !bus.abort),
        .reload   (btu_c),
        .load_val (accept ? first_val : div_l),
        .tc       (tc)
    );

    assign bus.busy  = (state == ST_RUN);
    assign bus.btu   = btu_c;
    assign bus.done  = done_c;
    assign bus.count = count;

endmodule
